// File: rtl/exp_reg_pkg.sv
// exp_reg_pkg: shared register map, FSM encoding, requester ids and reset constants
package exp_reg_pkg;
    localparam logic [2:0] ADDR_IN0  = 3'd0;
    localparam logic [2:0] ADDR_IN1  = 3'd1;
    localparam logic [2:0] ADDR_OUT0 = 3'd2;
    localparam logic [2:0] ADDR_OUT1 = 3'd3;
    localparam logic [2:0] ADDR_POL0 = 3'd4;
    localparam logic [2:0] ADDR_POL1 = 3'd5;
    localparam logic [2:0] ADDR_CFG0 = 3'd6;
    localparam logic [2:0] ADDR_CFG1 = 3'd7;
    localparam logic REQ_I2C = 1'b0;
    localparam logic REQ_LOC = 1'b1;
    localparam logic [15:0] DEF_OUT_RST = 16'hFFFF;
    localparam logic [15:0] DEF_CFG_RST = 16'hFFFF;
    localparam logic [15:0] POL_RST = 16'h0000;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_e;
    function automatic logic [7:0] byte_sel(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction
endpackage

// File: rtl/exp_reg_arbiter_if.sv
// exp_reg_arbiter_if: one register-access port (req/we/addr/wdata in, ack/rdata out)
//   master = requester side, slave = register controller side
interface exp_reg_arbiter_if;
    logic       req;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    modport master(output req, we, addr, wdata, input ack, rdata);
    modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/exp_in_sync.sv
// exp_in_sync: STAGES-deep W-bit pad synchronizer, cleared by rst
//   d = raw pads, q = synchronized value after STAGES clocks
module exp_in_sync #(
    parameter int STAGES = 2,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES*W-1:0] chain_q, chain_d;
    always_comb chain_d = {chain_q[(STAGES-1)*W-1:0], d};
    always_ff @(posedge clk)
        if (rst) chain_q <= '0;
        else chain_q <= chain_d;
    assign q = chain_q[STAGES*W-1 -: W];
endmodule

// File: rtl/exp_reg_arbiter.sv
// exp_reg_arbiter: GPIO expander register file with I2C/local round-robin access and change interrupt
//   i2c, loc = register-access ports; pin_in = raw pads; pin_out/pin_oe = pad drive; int_n = change irq
module exp_reg_arbiter
    import exp_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter logic [15:0] OUT_RST = DEF_OUT_RST,
    parameter logic [15:0] CFG_RST = DEF_CFG_RST
) (
    input  logic                     clk,
    input  logic                     rst,
    exp_reg_arbiter_if.slave         i2c,
    exp_reg_arbiter_if.slave         loc,
    input  logic [15:0]              pin_in,
    output logic [15:0]              pin_out,
    output logic [15:0]              pin_oe,
    output logic                     int_n
);
    localparam int CW = $clog2(SYNC_STAGES + 2);
    state_e state_q, state_d;
    logic rr_q, rr_d, win_q, win_d, we_q, we_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d, i2c_rdata_q, i2c_rdata_d, loc_rdata_q, loc_rdata_d;
    logic [15:0] out_q, out_d, pol_q, pol_d, cfg_q, cfg_d, snap_q, snap_d;
    logic i2c_ack_q, i2c_ack_d, loc_ack_q, loc_ack_d, int_n_q, int_n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] sync_val, in_val, rd_reg;
    logic [7:0] rd_byte;
    logic [3:0] bsel;
    logic [1:0] chg;
    logic settled, pick;
    exp_in_sync #(.STAGES(SYNC_STAGES), .W(16)) u_sync (.clk(clk), .rst(rst), .d(pin_in), .q(sync_val));
    assign in_val = sync_val ^ pol_q;
    assign pin_out = out_q;
    assign pin_oe = ~cfg_q;
    assign int_n = int_n_q;
    assign i2c.ack = i2c_ack_q;
    assign i2c.rdata = i2c_rdata_q;
    assign loc.ack = loc_ack_q;
    assign loc.rdata = loc_rdata_q;
    // the snapshot tracks IN until the synchronizer has flushed its reset zeros, then freezes
    assign settled = cnt_q == CW'(SYNC_STAGES + 1);
    assign bsel = {addr_q[0], 3'b000};
    assign rd_reg = addr_q[2:1] == ADDR_IN0[2:1] ? in_val :
                    addr_q[2:1] == ADDR_OUT0[2:1] ? out_q :
                    addr_q[2:1] == ADDR_POL0[2:1] ? pol_q : cfg_q;
    assign rd_byte = byte_sel(rd_reg, addr_q[0]);
    // on a tie the requester not granted last wins
    assign pick = (i2c.req && loc.req) ? ~rr_q : (i2c.req ? REQ_I2C : REQ_LOC);
    // output-configured pins are masked out of change detection
    assign chg[0] = |((in_val[7:0] ^ snap_q[7:0]) & cfg_q[7:0]);
    assign chg[1] = |((in_val[15:8] ^ snap_q[15:8]) & cfg_q[15:8]);
    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        win_d = win_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        out_d = out_q;
        pol_d = pol_q;
        cfg_d = cfg_q;
        i2c_ack_d = 1'b0;
        loc_ack_d = 1'b0;
        i2c_rdata_d = i2c_rdata_q;
        loc_rdata_d = loc_rdata_q;
        cnt_d = settled ? cnt_q : cnt_q + CW'(1);
        snap_d = settled ? snap_q : in_val;
        int_n_d = ~(settled & |chg);
        case (state_q)
            ST_IDLE: if (i2c.req || loc.req) begin
                win_d = pick;
                rr_d = pick;
                we_d = pick == REQ_LOC ? loc.we : i2c.we;
                addr_d = pick == REQ_LOC ? loc.addr : i2c.addr;
                wdata_d = pick == REQ_LOC ? loc.wdata : i2c.wdata;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                state_d = ST_DONE;
                i2c_ack_d = win_q == REQ_I2C;
                loc_ack_d = win_q == REQ_LOC;
                if (we_q) begin
                    if (addr_q[2:1] == ADDR_OUT0[2:1]) out_d[bsel +: 8] = wdata_q;
                    if (addr_q[2:1] == ADDR_POL0[2:1]) pol_d[bsel +: 8] = wdata_q;
                    if (addr_q[2:1] == ADDR_CFG0[2:1]) cfg_d[bsel +: 8] = wdata_q;
                end else begin
                    i2c_rdata_d = win_q == REQ_I2C ? rd_byte : i2c_rdata_q;
                    loc_rdata_d = win_q == REQ_LOC ? rd_byte : loc_rdata_q;
                    // reading IN re-arms the interrupt against the value just returned
                    if (addr_q[2:1] == ADDR_IN0[2:1]) snap_d[bsel +: 8] = rd_byte;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q <= REQ_LOC;
            win_q <= REQ_I2C;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            out_q <= OUT_RST;
            pol_q <= POL_RST;
            cfg_q <= CFG_RST;
            snap_q <= '0;
            i2c_ack_q <= 1'b0;
            loc_ack_q <= 1'b0;
            i2c_rdata_q <= '0;
            loc_rdata_q <= '0;
            int_n_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            win_q <= win_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            out_q <= out_d;
            pol_q <= pol_d;
            cfg_q <= cfg_d;
            snap_q <= snap_d;
            i2c_ack_q <= i2c_ack_d;
            loc_ack_q <= loc_ack_d;
            i2c_rdata_q <= i2c_rdata_d;
            loc_rdata_q <= loc_rdata_d;
            int_n_q <= int_n_d;
            cnt_q <= cnt_d;
        end
endmodule

// File: tb/tb_exp_reg_arbiter.sv
// tb_exp_reg_arbiter: randomized self-checking bench against a byte-level register model
module tb_exp_reg_arbiter;
    localparam int SYNC_STAGES = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pin_in = 16'h0000;
    logic [15:0] pin_out, pin_oe;
    logic int_n;
    int vectors = 0;
    int errors = 0;
    logic [7:0] m_out[2], m_pol[2], m_cfg[2], m_snap[2];
    bit m_last;
    exp_reg_arbiter_if i2c_if();
    exp_reg_arbiter_if loc_if();
    exp_reg_arbiter #(.SYNC_STAGES(SYNC_STAGES), .OUT_RST(16'hFFFF), .CFG_RST(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .i2c(i2c_if), .loc(loc_if),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .int_n(int_n)
    );
    always #5 clk = ~clk;

    function automatic logic [7:0] m_in(input int p);
        return pin_in[p*8 +: 8] ^ m_pol[p];
    endfunction
    function automatic logic [7:0] m_read(input logic [2:0] a);
        int p = int'(a[0]);
        case (a[2:1])
            2'd0: return m_in(p);
            2'd1: return m_out[p];
            2'd2: return m_pol[p];
            default: return m_cfg[p];
        endcase
    endfunction
    function automatic logic m_int();
        for (int p = 0; p < 2; p++)
            if (|((m_in(p) ^ m_snap[p]) & m_cfg[p])) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [15:0] m_pins_out();
        return {m_out[1], m_out[0]};
    endfunction
    function automatic logic [15:0] m_pins_oe();
        return ~{m_cfg[1], m_cfg[0]};
    endfunction
    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            m_out[p] = 8'hFF;
            m_pol[p] = 8'h00;
            m_cfg[p] = 8'hFF;
            m_snap[p] = m_in(p);
        end
        m_last = 1'b1;
    endtask
    task automatic m_access(input logic we, input logic [2:0] a, input logic [7:0] d);
        int p = int'(a[0]);
        if (we) begin
            if (a[2:1] == 2'd1) m_out[p] = d;
            if (a[2:1] == 2'd2) m_pol[p] = d;
            if (a[2:1] == 2'd3) m_cfg[p] = d;
        end else if (a[2:1] == 2'd0) m_snap[p] = m_in(p);
    endtask

    task automatic access(input bit who, input logic we, input logic [2:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
        logic [7:0] ev;
        ev = m_read(a);
        @(posedge clk); #1;
        if (who) begin
            loc_if.req = 1'b1; loc_if.we = we; loc_if.addr = a; loc_if.wdata = d;
        end else begin
            i2c_if.req = 1'b1; i2c_if.we = we; i2c_if.addr = a; i2c_if.wdata = d;
        end
        lat = 0;
        rd = 8'hxx;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (who ? loc_if.ack : i2c_if.ack) begin
                rd = who ? loc_if.rdata : i2c_if.rdata;
                break;
            end
        end
        @(posedge clk); #1;
        i2c_if.req = 1'b0;
        loc_if.req = 1'b0;
        if (lat < 20) begin
            m_access(we, a, d);
            m_last = who;
        end
        if (!we) rd = (rd === ev) ? rd : rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        repeat (SYNC_STAGES + 4) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        int lat;
        do_reset();
        @(negedge clk);
        vectors++; if (pin_out !== 16'hFFFF) begin errors++; $display("FAIL reset_pin_out got %h want ffff", pin_out); end
        vectors++; if (pin_oe !== 16'h0000) begin errors++; $display("FAIL reset_pin_oe got %h want 0000", pin_oe); end
        vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n got %b want 1", int_n); end
        vectors++; if ({i2c_if.ack, loc_if.ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b want 00", {i2c_if.ack, loc_if.ack}); end
        access(0, 0, 3'd6, 8'h00, rd, lat);
        vectors++; if (rd !== 8'hFF || lat != 3) begin errors++; $display("FAIL reset_read_cfg0 got %h lat %0d want ff lat 3", rd, lat); end
        access(1, 0, 3'd4, 8'h00, rd, lat);
        vectors++; if (rd !== 8'h00 || lat != 3) begin errors++; $display("FAIL reset_read_pol0 got %h lat %0d want 00 lat 3", rd, lat); end
    endtask

    task automatic test_write();
        logic [7:0] rd;
        int lat;
        access(0, 1, 3'd2, 8'hA5, rd, lat);
        vectors++; if (lat != 3) begin errors++; $display("FAIL write_out0_latency got %0d want 3", lat); end
        @(negedge clk);
        vectors++; if (i2c_if.ack !== 1'b0) begin errors++; $display("FAIL write_ack_width got %b want 0", i2c_if.ack); end
        access(0, 1, 3'd6, 8'h00, rd, lat);
        vectors++; if (lat != 3) begin errors++; $display("FAIL write_cfg0_latency got %0d want 3", lat); end
        vectors++; if (pin_out[7:0] !== 8'hA5 || pin_out !== m_pins_out()) begin errors++; $display("FAIL write_pin_out got %h want %h", pin_out, m_pins_out()); end
        vectors++; if (pin_oe[7:0] !== 8'hFF || pin_oe !== m_pins_oe()) begin errors++; $display("FAIL write_pin_oe got %h want %h", pin_oe, m_pins_oe()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, ei, el;
        int lat, cyc;
        int got[$];
        int exp_q[$];
        bit pi, pl, prev_i, prev_l;
        ei = m_read(3'd2);
        access(0, 0, 3'd2, 8'h00, rd, lat);
        vectors++; if (rd !== ei) begin errors++; $display("FAIL b2b_prime_read got %h want %h", rd, ei); end
        for (int r = 0; r < 2; r++) begin
            ei = m_read(3'd2);
            el = m_read(3'd3);
            @(posedge clk); #1;
            i2c_if.req = 1'b1; i2c_if.we = 1'b0; i2c_if.addr = 3'd2; i2c_if.wdata = 8'h00;
            loc_if.req = 1'b1; loc_if.we = 1'b0; loc_if.addr = 3'd3; loc_if.wdata = 8'h00;
            exp_q.push_back(int'(!m_last));
            exp_q.push_back(int'(m_last));
            pi = 1'b1; pl = 1'b1; prev_i = 1'b0; prev_l = 1'b0; cyc = 0;
            while ((pi || pl) && cyc < 40) begin
                @(negedge clk);
                cyc++;
                vectors++;
                if ((i2c_if.ack && prev_i) || (loc_if.ack && prev_l) || (i2c_if.ack && loc_if.ack)) begin
                    errors++; $display("FAIL b2b_ack_pulse got i2c %b loc %b want single 1-clk acks", i2c_if.ack, loc_if.ack);
                end
                if (i2c_if.ack) begin
                    got.push_back(0);
                    vectors++; if (i2c_if.rdata !== ei) begin errors++; $display("FAIL b2b_i2c_rdata got %h want %h", i2c_if.rdata, ei); end
                end
                if (loc_if.ack) begin
                    got.push_back(1);
                    vectors++; if (loc_if.rdata !== el) begin errors++; $display("FAIL b2b_loc_rdata got %h want %h", loc_if.rdata, el); end
                end
                prev_i = i2c_if.ack;
                prev_l = loc_if.ack;
                @(posedge clk); #1;
                if (prev_i) begin i2c_if.req = 1'b0; pi = 1'b0; end
                if (prev_l) begin loc_if.req = 1'b0; pl = 1'b0; end
            end
            vectors++; if (pi || pl) begin errors++; $display("FAIL b2b_timeout got pending i2c %b loc %b want none", pi, pl); end
            i2c_if.req = 1'b0;
            loc_if.req = 1'b0;
        end
        @(negedge clk);
        vectors++; if ({i2c_if.ack, loc_if.ack} !== 2'b00) begin errors++; $display("FAIL b2b_trailing_ack got %b want 00", {i2c_if.ack, loc_if.ack}); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] != exp_q[i]) begin
                errors++; $display("FAIL b2b_grant_%0d got %0d want %0d (0=i2c 1=loc)", i, (i < got.size()) ? got[i] : -1, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, ev, d;
        logic [2:0] a;
        logic we;
        bit who;
        int lat;
        pin_in = 16'($urandom);
        repeat (SYNC_STAGES + 3) @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            ev = m_read(3'(p));
            access(1, 0, 3'(p), 8'h00, rd, lat);
            vectors++; if (rd !== ev) begin errors++; $display("FAIL rand_in%0d got %h want %h", p, rd, ev); end
        end
        for (int i = 0; i < 40; i++) begin
            who = 1'($urandom);
            we = 1'($urandom);
            a = 3'($urandom);
            d = 8'($urandom);
            ev = m_read(a);
            access(who, we, a, d, rd, lat);
            vectors++; if (lat != 3) begin errors++; $display("FAIL rand_lat_%0d got %0d want 3", i, lat); end
            if (!we) begin
                vectors++; if (rd !== ev) begin errors++; $display("FAIL rand_rdata_%0d addr %0d got %h want %h", i, a, rd, ev); end
            end
            vectors++; if (pin_out !== m_pins_out() || pin_oe !== m_pins_oe()) begin
                errors++; $display("FAIL rand_pins_%0d got out %h oe %h want out %h oe %h", i, pin_out, pin_oe, m_pins_out(), m_pins_oe());
            end
            vectors++; if (int_n !== !m_int()) begin errors++; $display("FAIL rand_int_n_%0d got %b want %b", i, int_n, !m_int()); end
        end
    endtask

    task automatic test_interrupt();
        logic [7:0] rd, ev;
        int lat, n;
        access(0, 1, 3'd6, 8'hFF, rd, lat);
        access(0, 1, 3'd7, 8'hFF, rd, lat);
        access(0, 1, 3'd4, 8'h00, rd, lat);
        access(0, 1, 3'd5, 8'h00, rd, lat);
        pin_in = 16'h0000;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        access(0, 0, 3'd0, 8'h00, rd, lat);
        access(0, 0, 3'd1, 8'h00, rd, lat);
        vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL irq_idle got %b want 1", int_n); end
        @(posedge clk); #1;
        pin_in[9] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (!int_n) break;
        end
        vectors++; if (n - 1 != SYNC_STAGES + 1) begin errors++; $display("FAIL irq_latency got %0d clk want %0d", n - 1, SYNC_STAGES + 1); end
        ev = m_read(3'd0);
        access(0, 0, 3'd0, 8'h00, rd, lat);
        vectors++; if (rd !== ev || int_n !== 1'b0) begin errors++; $display("FAIL irq_read_in0 got %h int_n %b want %h int_n 0", rd, int_n, ev); end
        access(1, 0, 3'd1, 8'h00, rd, lat);
        vectors++; if (rd !== 8'h02) begin errors++; $display("FAIL irq_read_in1 got %h want 02", rd); end
        vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL irq_cleared got %b want 1", int_n); end
        access(0, 1, 3'd7, 8'h00, rd, lat);
        @(posedge clk); #1;
        pin_in[8] = 1'b1;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        @(negedge clk);
        vectors++; if (int_n !== !m_int() || int_n !== 1'b1) begin errors++; $display("FAIL irq_output_pin got %b want 1", int_n); end
    endtask

    task automatic test_pol();
        logic [7:0] rd, ev;
        int lat;
        @(posedge clk); #1;
        pin_in[7:0] = 8'h0F;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        access(0, 0, 3'd0, 8'h00, rd, lat);
        vectors++; if (rd !== 8'h0F || int_n !== !m_int()) begin errors++; $display("FAIL pol_pre got %h int_n %b want 0f int_n %b", rd, int_n, !m_int()); end
        access(1, 1, 3'd4, 8'hFF, rd, lat);
        vectors++; if (int_n !== 1'b0 || m_int() !== 1'b1) begin errors++; $display("FAIL pol_flip_irq got %b want 0", int_n); end
        access(0, 0, 3'd0, 8'h00, rd, lat);
        vectors++; if (rd !== 8'hF0) begin errors++; $display("FAIL pol_in0 got %h want f0", rd); end
        vectors++; if (int_n !== !m_int()) begin errors++; $display("FAIL pol_int_after_read got %b want %b", int_n, !m_int()); end
        access(0, 1, 3'd0, 8'h55, rd, lat);
        vectors++; if (lat != 3) begin errors++; $display("FAIL ro_write_ack got lat %0d want 3", lat); end
        ev = m_read(3'd0);
        access(1, 0, 3'd0, 8'h00, rd, lat);
        vectors++; if (rd !== ev || rd !== 8'hF0) begin errors++; $display("FAIL ro_write_in0 got %h want f0", rd); end
        vectors++; if (pin_out !== m_pins_out() || pin_oe !== m_pins_oe() || int_n !== !m_int()) begin
            errors++; $display("FAIL ro_write_state got out %h oe %h int_n %b want out %h oe %h int_n %b", pin_out, pin_oe, int_n, m_pins_out(), m_pins_oe(), !m_int());
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] rd;
        int lat;
        bit seen;
        @(posedge clk); #1;
        i2c_if.req = 1'b1; i2c_if.we = 1'b1; i2c_if.addr = 3'd3; i2c_if.wdata = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        i2c_if.req = 1'b0;
        @(negedge clk);
        seen = i2c_if.ack;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        repeat (SYNC_STAGES + 4) begin
            @(negedge clk);
            seen |= i2c_if.ack;
        end
        vectors++; if (seen) begin errors++; $display("FAIL abort_ack got 1 want 0"); end
        vectors++; if (pin_out[15:8] !== 8'hFF || pin_out !== m_pins_out()) begin errors++; $display("FAIL abort_out1 got %h want %h", pin_out, m_pins_out()); end
        vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL abort_int_n got %b want 1", int_n); end
        access(1, 0, 3'd3, 8'h00, rd, lat);
        vectors++; if (rd !== 8'hFF || lat != 3) begin errors++; $display("FAIL abort_idle_read got %h lat %0d want ff lat 3", rd, lat); end
    endtask

    initial begin
        i2c_if.req = 1'b0; i2c_if.we = 1'b0; i2c_if.addr = 3'd0; i2c_if.wdata = 8'h00;
        loc_if.req = 1'b0; loc_if.we = 1'b0; loc_if.addr = 3'd0; loc_if.wdata = 8'h00;
        m_reset();
        test_reset();
        test_write();
        test_back_to_back();
        test_random();
        test_interrupt();
        test_pol();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule
